button_conditioner: RTL

Input front end for `neurosync`: synchronises, debounces and edge-detects the raw player inputs (`botoes`, `mais`, `menos`, `confirma`, `jogar`), then hands single-cycle pulses and a validated one-hot `jogada` to the game control unit. It sits directly upstream of `neurosync`. Its outputs replace the raw pad signals so the game FSM never sees bounce, level-held buttons or multi-button presses.

---
 rtl/button_conditioner_pkg.sv | 23 ++
 rtl/debounce_pulse.sv | 46 ++++
 rtl/button_conditioner.sv | 113 +++++++++++
 3 files changed

// File: rtl/button_conditioner_pkg.sv
// Shared definitions for the neurosync input front end: button FSM states,
// default debounce length and counter sizing helpers.
package button_conditioner_pkg;

    typedef enum logic [1:0] {
        OCIOSO        = 2'd0,
        FILTRANDO     = 2'd1,
        EMITE         = 2'd2,
        ESPERA_SOLTAR = 2'd3
    } estado_t;

    localparam int DEBOUNCE_DEFAULT = 4;

    // Wide enough to hold the full debounce count without wrapping.
    function automatic int cnt_width(input int cycles);
        return $clog2(cycles + 1);
    endfunction

    function automatic logic is_one_hot(input logic [3:0] value);
        return (value != 4'd0) && ((value & (value - 4'd1)) == 4'd0);
    endfunction

endpackage

// File: rtl/debounce_pulse.sv
// One control input: 2-flop synchroniser, stable-level debouncer and a
// single-cycle pulse on each accepted press.
module debounce_pulse
    import button_conditioner_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEBOUNCE_DEFAULT
) (
    input  logic clock,
    input  logic reset,
    input  logic raw,
    output logic pulse
);

    localparam int CW = cnt_width(DEBOUNCE_CYCLES);
    localparam logic [CW-1:0] LAST = CW'(DEBOUNCE_CYCLES - 1);

    logic [1:0]    sync;
    logic          level;
    logic          level_q;
    logic [CW-1:0] cnt;

    // The counter only runs while the synchronised sample disagrees with the
    // accepted level; any agreeing sample restarts the stability window.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            sync    <= 2'b00;
            level   <= 1'b0;
            level_q <= 1'b0;
            cnt     <= '0;
            pulse   <= 1'b0;
        end else begin
            sync    <= {sync[0], raw};
            level_q <= level;
            pulse   <= level & ~level_q;
            if (sync[1] == level) begin
                cnt <= '0;
            end else if (cnt >= LAST) begin
                level <= sync[1];
                cnt   <= '0;
            end else begin
                cnt <= cnt + CW'(1);
            end
        end
    end

endmodule

// File: rtl/button_conditioner.sv
// Top of the input front end: four debounced control pulses plus the
// game-button FSM that validates one-hot plays.
module button_conditioner
    import button_conditioner_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEBOUNCE_DEFAULT
) (
    input  logic       clock,
    input  logic       reset,
    input  logic [3:0] botoes,
    input  logic       mais,
    input  logic       menos,
    input  logic       confirma,
    input  logic       jogar,
    output logic [3:0] jogada,
    output logic       jogada_valida,
    output logic       multipla,
    output logic       mais_pulso,
    output logic       menos_pulso,
    output logic       confirma_pulso,
    output logic       jogar_pulso,
    output logic [1:0] db_estado
);

    localparam int CW = cnt_width(DEBOUNCE_CYCLES);
    localparam logic [CW-1:0] LAST = CW'(DEBOUNCE_CYCLES - 1);

    logic [3:0]    botoes_meta;
    logic [3:0]    s_botoes;
    logic [3:0]    padrao;
    logic [CW-1:0] cnt;
    estado_t       estado;

    debounce_pulse #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_mais (
        .clock(clock), .reset(reset), .raw(mais), .pulse(mais_pulso)
    );
    debounce_pulse #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_menos (
        .clock(clock), .reset(reset), .raw(menos), .pulse(menos_pulso)
    );
    debounce_pulse #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_confirma (
        .clock(clock), .reset(reset), .raw(confirma), .pulse(confirma_pulso)
    );
    debounce_pulse #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_jogar (
        .clock(clock), .reset(reset), .raw(jogar), .pulse(jogar_pulso)
    );

    assign db_estado = estado;

    // A press is accepted only after the same pattern has been seen for the
    // full window; the release must then be equally stable before re-arming.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            botoes_meta   <= 4'd0;
            s_botoes      <= 4'd0;
            padrao        <= 4'd0;
            cnt           <= '0;
            estado        <= OCIOSO;
            jogada        <= 4'd0;
            jogada_valida <= 1'b0;
            multipla      <= 1'b0;
        end else begin
            botoes_meta   <= botoes;
            s_botoes      <= botoes_meta;
            jogada_valida <= 1'b0;
            multipla      <= 1'b0;
            case (estado)
                OCIOSO: begin
                    if (s_botoes != 4'd0) begin
                        padrao <= s_botoes;
                        cnt    <= CW'(1);
                        estado <= (DEBOUNCE_CYCLES == 1) ? EMITE : FILTRANDO;
                    end
                end
                FILTRANDO: begin
                    if (s_botoes == 4'd0) begin
                        cnt    <= '0;
                        estado <= OCIOSO;
                    end else if (s_botoes != padrao) begin
                        padrao <= s_botoes;
                        cnt    <= CW'(1);
                    end else begin
                        cnt <= cnt + CW'(1);
                        if (cnt >= LAST) begin
                            estado <= EMITE;
                        end
                    end
                end
                EMITE: begin
                    if (is_one_hot(padrao)) begin
                        jogada        <= padrao;
                        jogada_valida <= 1'b1;
                    end else begin
                        multipla <= 1'b1;
                    end
                    cnt    <= '0;
                    estado <= ESPERA_SOLTAR;
                end
                ESPERA_SOLTAR: begin
                    if (s_botoes != 4'd0) begin
                        cnt <= '0;
                    end else if (cnt >= LAST) begin
                        cnt    <= '0;
                        estado <= OCIOSO;
                    end else begin
                        cnt <= cnt + CW'(1);
                    end
                end
                default: estado <= OCIOSO;
            endcase
        end
    end

endmodule
